// File: rtl/cache_pkg.sv
// Shared types and constants for the two-way write-back data cache.
// The set word is {lru, way1, way0}, and each way is {valid, dirty, tag, data}.
package cache_pkg;

  localparam int LINE_WIDTH = 32;
  localparam int TAG_WIDTH  = 21;
  localparam int SET_SIZE   = 2 * (TAG_WIDTH + LINE_WIDTH + 2) + 1;

  typedef struct packed {
    logic                  valid;
    logic                  dirty;
    logic [TAG_WIDTH-1:0]  tag;
    logic [LINE_WIDTH-1:0] data;
  } way_t;

  typedef struct packed {
    logic lru;
    way_t way1;
    way_t way0;
  } set_t;

  typedef enum logic [1:0] {
    INIT      = 2'd0,
    IDLE      = 2'd1,
    WRITEBACK = 2'd2,
    ALLOCATE  = 2'd3
  } state_t;

  // Return a copy of the set with one way replaced.
  // The LRU bit and the other way are left untouched.
  function automatic set_t set_replace_way(input set_t s, input logic sel, input way_t w);
    set_t r;
    r = s;
    if (sel) begin
      r.way1 = w;
    end else begin
      r.way0 = w;
    end
    return r;
  endfunction

endpackage

// File: rtl/cache_way_cmp.sv
// Tag compare for one way.
// A way hits only when it holds a valid line with a matching tag.
module cache_way_cmp
  import cache_pkg::*;
(
  input  way_t                 way,
  input  logic [TAG_WIDTH-1:0] tag,
  output logic                 hit
);

  logic unused_way_s;

  assign unused_way_s = way.dirty ^ (^way.data);

  // Hit detection for this way
  assign hit = way.valid && (way.tag == tag);

endmodule

// File: rtl/dcache_controller.sv
// Two-way set-associative, write-back, write-allocate data-cache controller.
// Define CACHE_STATS_EN to add the hit_count and miss_count statistics outputs.
// The set SRAM is read combinationally and written on the rising edge.
// Misses evict the LRU way: a dirty victim is written back first,
// then the line is refilled.
module dcache_controller
  import cache_pkg::*;
#(
  parameter int ADDR_WIDTH       = 32,
  parameter int DATA_WIDTH       = 32,
  parameter int CACHE_ADDR_WIDTH = 9
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cpu_re,
  input  logic                        cpu_we,
  input  logic [ADDR_WIDTH-1:0]       cpu_addr,
  input  logic [DATA_WIDTH-1:0]       cpu_wdata,
  output logic [DATA_WIDTH-1:0]       cpu_rdata,
  output logic                        stall,
  output logic [CACHE_ADDR_WIDTH-1:0] sram_addr,
  output logic                        sram_re,
  output logic                        sram_we,
  output logic [SET_SIZE-1:0]         sram_wd,
  input  logic [SET_SIZE-1:0]         sram_rd,
  output logic                        mem_req,
  output logic                        mem_we,
  output logic [ADDR_WIDTH-1:0]       mem_addr,
  output logic [DATA_WIDTH-1:0]       mem_wdata,
  input  logic                        mem_ready,
  input  logic [DATA_WIDTH-1:0]       mem_rdata
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]                 hit_count,
  output logic [31:0]                 miss_count
`endif
);

  state_t                      state_r, state_nxt_s;
  logic [CACHE_ADDR_WIDTH-1:0] init_cnt_r;
  logic                        victim_way_r;
  logic [TAG_WIDTH-1:0]        req_tag_r;
  logic [CACHE_ADDR_WIDTH-1:0] req_idx_r;
  logic [TAG_WIDTH-1:0]        victim_tag_r;
  logic [LINE_WIDTH-1:0]       victim_data_r;

  set_t                        rd_set_s;
  set_t                        wr_set_s;
  way_t                        victim_s;
  way_t                        fill_way_s;
  logic [TAG_WIDTH-1:0]        req_tag_s;
  logic [CACHE_ADDR_WIDTH-1:0] req_idx_s;
  logic                        hit0_s, hit1_s;
  logic                        cpu_access_s;
  logic                        hit_s;
  logic                        miss_s;
  logic                        fill_done_s;
  logic                        unused_addr_s;

  assign rd_set_s      = set_t'(sram_rd);
  assign req_tag_s     = cpu_addr[ADDR_WIDTH-1 -: TAG_WIDTH];
  assign req_idx_s     = cpu_addr[CACHE_ADDR_WIDTH+1:2];
  assign cpu_access_s  = cpu_re | cpu_we;
  assign victim_s      = rd_set_s.lru ? rd_set_s.way1 : rd_set_s.way0;
  assign unused_addr_s = ^cpu_addr[1:0];

  assign fill_way_s = '{valid: 1'b1, dirty: 1'b0, tag: req_tag_r, data: mem_rdata};

  cache_way_cmp u_cmp_way0 (
    .way (rd_set_s.way0),
    .tag (req_tag_s),
    .hit (hit0_s)
  );

  cache_way_cmp u_cmp_way1 (
    .way (rd_set_s.way1),
    .tag (req_tag_s),
    .hit (hit1_s)
  );

  // Next-state and output decode; reset forces every output to its quiet value
  always_comb begin
    state_nxt_s = state_r;
    stall       = 1'b1;
    cpu_rdata   = '0;
    sram_addr   = req_idx_r;
    sram_re     = 1'b0;
    sram_we     = 1'b0;
    sram_wd     = '0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    wr_set_s    = rd_set_s;
    hit_s       = 1'b0;
    miss_s      = 1'b0;
    fill_done_s = 1'b0;
    if (rst) begin
      state_nxt_s = INIT;
    end else begin
      case (state_r)
        INIT: begin
          sram_we   = 1'b1;
          sram_addr = init_cnt_r;
          sram_wd   = '0;
          if (init_cnt_r == {CACHE_ADDR_WIDTH{1'b1}}) begin
            state_nxt_s = IDLE;
          end else begin
            state_nxt_s = INIT;
          end
        end
        IDLE: begin
          sram_re   = 1'b1;
          sram_addr = req_idx_s;
          if (!cpu_access_s) begin
            stall = 1'b0;
          end else if (hit0_s || hit1_s) begin
            // The hit way becomes most recently used, so LRU points at the other way
            stall = 1'b0;
            hit_s = 1'b1;
            if (hit0_s) begin
              wr_set_s.lru = 1'b1;
              if (cpu_we) begin
                wr_set_s.way0.data  = cpu_wdata;
                wr_set_s.way0.dirty = 1'b1;
              end else begin
                cpu_rdata = rd_set_s.way0.data;
              end
            end else begin
              wr_set_s.lru = 1'b0;
              if (cpu_we) begin
                wr_set_s.way1.data  = cpu_wdata;
                wr_set_s.way1.dirty = 1'b1;
              end else begin
                cpu_rdata = rd_set_s.way1.data;
              end
            end
            sram_we = 1'b1;
            sram_wd = wr_set_s;
          end else begin
            miss_s = 1'b1;
            if (victim_s.valid && victim_s.dirty) begin
              state_nxt_s = WRITEBACK;
            end else begin
              state_nxt_s = ALLOCATE;
            end
          end
        end
        WRITEBACK: begin
          mem_req   = 1'b1;
          mem_we    = 1'b1;
          mem_addr  = {victim_tag_r, req_idx_r, 2'b00};
          mem_wdata = victim_data_r;
          if (mem_ready) begin
            state_nxt_s = ALLOCATE;
          end else begin
            state_nxt_s = WRITEBACK;
          end
        end
        ALLOCATE: begin
          // Read the set back so the untouched way and LRU survive the fill write
          sram_re   = 1'b1;
          sram_addr = req_idx_r;
          mem_req   = 1'b1;
          mem_addr  = {req_tag_r, req_idx_r, 2'b00};
          if (mem_ready) begin
            wr_set_s    = set_replace_way(rd_set_s, victim_way_r, fill_way_s);
            sram_we     = 1'b1;
            sram_wd     = wr_set_s;
            fill_done_s = 1'b1;
            state_nxt_s = IDLE;
          end else begin
            state_nxt_s = ALLOCATE;
          end
        end
        default: begin
          state_nxt_s = INIT;
        end
      endcase
    end
  end

  // State register and INIT sweep counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= INIT;
      init_cnt_r <= '0;
    end else begin
      state_r <= state_nxt_s;
      if (state_r == INIT) begin
        init_cnt_r <= init_cnt_r + {{(CACHE_ADDR_WIDTH-1){1'b0}}, 1'b1};
      end else begin
        init_cnt_r <= init_cnt_r;
      end
    end
  end

  // Capture the request and the victim line when a miss is detected
  always_ff @(posedge clk) begin
    if (rst) begin
      victim_way_r  <= 1'b0;
      req_tag_r     <= '0;
      req_idx_r     <= '0;
      victim_tag_r  <= '0;
      victim_data_r <= '0;
    end else if (miss_s) begin
      victim_way_r  <= rd_set_s.lru;
      req_tag_r     <= req_tag_s;
      req_idx_r     <= req_idx_s;
      victim_tag_r  <= victim_s.tag;
      victim_data_r <= victim_s.data;
    end else begin
      victim_way_r  <= victim_way_r;
      req_tag_r     <= req_tag_r;
      req_idx_r     <= req_idx_r;
      victim_tag_r  <= victim_tag_r;
      victim_data_r <= victim_data_r;
    end
  end

`ifdef CACHE_STATS_EN
  logic replay_r;

  // Hit/miss statistics; the guaranteed hit replaying a refilled request is not counted
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_count  <= 32'd0;
      miss_count <= 32'd0;
      replay_r   <= 1'b0;
    end else begin
      if (hit_s && !replay_r) begin
        hit_count <= hit_count + 32'd1;
      end else begin
        hit_count <= hit_count;
      end
      if (miss_s) begin
        miss_count <= miss_count + 32'd1;
      end else begin
        miss_count <= miss_count;
      end
      if (fill_done_s) begin
        replay_r <= 1'b1;
      end else if (state_r == IDLE) begin
        replay_r <= 1'b0;
      end else begin
        replay_r <= replay_r;
      end
    end
  end
`else
  logic unused_stats_s;

  assign unused_stats_s = hit_s ^ fill_done_s;
`endif

endmodule

// File: tb/tb_dcache_controller.sv
// Self-checking bench for dcache_controller.
// A flat "architectural" memory plus a per-set tag/LRU shadow predicts hits,
// misses, write-backs and stall lengths.
// Directed scenarios run first, followed by random traffic.
`timescale 1ns/1ps
module tb_dcache_controller;

  localparam int SETS = 512;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         cpu_re = 1'b0, cpu_we = 1'b0;
  logic [31:0]  cpu_addr = 32'd0, cpu_wdata = 32'd0, cpu_rdata;
  logic         stall;
  logic [8:0]   sram_addr;
  logic         sram_re, sram_we;
  logic [110:0] sram_wd, sram_rd;
  logic         mem_req, mem_we;
  logic [31:0]  mem_addr, mem_wdata;
  logic         mem_ready = 1'b0;
  logic [31:0]  mem_rdata = 32'd0;
`ifdef CACHE_STATS_EN
  logic [31:0]  hit_count, miss_count;
`endif

  dcache_controller dut (
    .clk(clk), .rst(rst), .cpu_re(cpu_re), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .stall(stall),
    .sram_addr(sram_addr), .sram_re(sram_re), .sram_we(sram_we), .sram_wd(sram_wd),
    .sram_rd(sram_rd), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
`ifdef CACHE_STATS_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );

  always #5 clk = ~clk;

  // Set SRAM: combinational read, posedge write
  logic [110:0] sram_mem [SETS];
  always @(posedge clk) begin
    if (sram_we) sram_mem[sram_addr] <= sram_wd;
  end
  assign sram_rd = sram_mem[sram_addr];

  // Reference state
  logic [31:0] main_mem [int unsigned];
  logic [31:0] ref_mem  [int unsigned];
  bit          m_valid [SETS][2];
  bit          m_dirty [SETS][2];
  logic [20:0] m_tag   [SETS][2];
  bit          m_lru   [SETS];
  int          exp_hits, exp_misses;
  int          n_checks, n_errors;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] init_val(input int unsigned w);
    return (w * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] main_rd(input int unsigned w);
    return main_mem.exists(w) ? main_mem[w] : init_val(w);
  endfunction

  function automatic logic [31:0] ref_rd(input int unsigned w);
    return ref_mem.exists(w) ? ref_mem[w] : init_val(w);
  endfunction

  task automatic model_clear();
    for (int s = 0; s < SETS; s++) begin
      m_lru[s] = 1'b0;
      for (int k = 0; k < 2; k++) begin
        m_valid[s][k] = 1'b0;
        m_dirty[s][k] = 1'b0;
        m_tag[s][k]   = 21'd0;
      end
    end
    ref_mem    = main_mem;
    exp_hits   = 0;
    exp_misses = 0;
  endtask

  // Hold reset for some cycles with a pending load, then watch the INIT sweep
  task automatic do_reset(input int hold);
    int bad;
    int nz;
    rst = 1'b1; cpu_re = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_1004; mem_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check_val("rst_stall", stall, 1);
      check_val("rst_mem_req", mem_req, 0);
      check_val("rst_sram_we", sram_we, 0);
      check_val("rst_sram_re", sram_re, 0);
      check_val("rst_cpu_rdata", cpu_rdata, 0);
    end
    @(posedge clk); #1;
    rst = 1'b0; cpu_re = 1'b0;
    bad = 0;
    for (int i = 0; i < SETS; i++) begin
      logic [8:0] ia;
      ia = i[8:0];
      @(negedge clk);
      if (!(stall === 1'b1 && sram_we === 1'b1 && sram_addr === ia &&
            sram_wd === 111'd0 && mem_req === 1'b0)) bad++;
    end
    check_val("init_sweep_bad_cycles", bad, 0);
    @(negedge clk);
    check_val("init_done_stall", stall, 0);
    nz = 0;
    for (int s = 0; s < SETS; s++) if (sram_mem[s] !== 111'd0) nz++;
    check_val("init_sram_cleared", nz, 0);
`ifdef CACHE_STATS_EN
    check_val("stats_hit_reset", hit_count, 0);
    check_val("stats_miss_reset", miss_count, 0);
`endif
    model_clear();
    @(posedge clk); #1;
  endtask

  // One CPU access with a memory responder of fixed latency; all checks vs the model
  task automatic access(input bit is_store, input logic [31:0] addr,
                        input logic [31:0] wdata, input int lat);
    int unsigned w;
    logic [8:0]  idx;
    logic [20:0] tag;
    int          hw, way, stalls, waitc, exp_stall, phase;
    bit          victim, exp_wb, done;
    logic [31:0] wb_addr;
    w = addr >> 2; idx = addr[10:2]; tag = addr[31:11];
    hw = -1;
    for (int k = 0; k < 2; k++) if (m_valid[idx][k] && m_tag[idx][k] == tag) hw = k;
    exp_wb = 1'b0; exp_stall = 0; victim = 1'b0; wb_addr = 32'd0;
    if (hw < 0) begin
      victim    = m_lru[idx];
      exp_wb    = m_valid[idx][victim] && m_dirty[idx][victim];
      wb_addr   = {m_tag[idx][victim], idx, 2'b00};
      exp_stall = 1 + (lat + 1) + (exp_wb ? lat + 1 : 0);
      exp_misses++;
    end else begin
      exp_hits++;
    end
    cpu_we    = is_store;
    cpu_re    = is_store ? 1'($urandom_range(0, 1)) : 1'b1;
    cpu_addr  = {addr[31:2], 2'($urandom_range(0, 3))};
    cpu_wdata = wdata;
    stalls = 0; waitc = 0; done = 1'b0; phase = exp_wb ? 0 : 1;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      if (stall) begin
        stalls++;
        if (mem_req) begin
          check_val("mem_we", mem_we, (phase == 0));
          check_val("mem_addr", mem_addr, (phase == 0) ? wb_addr : {addr[31:2], 2'b00});
          if (phase == 0) check_val("mem_wdata", mem_wdata, ref_rd(wb_addr >> 2));
          if (waitc == lat) begin
            mem_ready = 1'b1;
            if (phase == 0) main_mem[wb_addr >> 2] = mem_wdata;
            else            mem_rdata = main_rd(w);
          end else begin
            check_val("sram_we_while_waiting", sram_we, 0);
          end
          waitc++;
        end
        @(posedge clk); #1;
        if (mem_ready) begin
          mem_ready = 1'b0; mem_rdata = $urandom; phase++; waitc = 0;
        end
      end else begin
        if (is_store) check_val("store_rdata_zero", cpu_rdata, 0);
        else          check_val("load_rdata", cpu_rdata, ref_rd(w));
        done = 1'b1;
        @(posedge clk); #1;
      end
    end
    check_val("access_completed", done, 1);
    check_val("stall_cycles", stalls, exp_stall);
    cpu_re = 1'b0; cpu_we = 1'b0;
    way = (hw < 0) ? int'(victim) : hw;
    if (hw < 0) begin
      m_valid[idx][way] = 1'b1; m_dirty[idx][way] = 1'b0; m_tag[idx][way] = tag;
    end
    m_lru[idx] = (way == 0);
    if (is_store) begin
      m_dirty[idx][way] = 1'b1;
      ref_mem[w] = wdata;
    end
  endtask

  initial begin
    n_checks = 0; n_errors = 0;
    for (int s = 0; s < SETS; s++) sram_mem[s] = {$urandom, $urandom, $urandom, $urandom};
    main_mem[32'h0000_1004 >> 2] = 32'hDEAD_BEEF;
    do_reset(3);

    // Cold load, clean victim, 3-cycle refill
    access(1'b0, 32'h0000_1004, 32'd0, 3);
    check_val("fill_lru", sram_mem[1][110], 1);
    check_val("fill_way0_valid", sram_mem[1][54], 1);
    check_val("fill_way0_data", sram_mem[1][31:0], 32'hDEAD_BEEF);

    // Store hit on the filled line
    access(1'b1, 32'h0000_1004, 32'h1234_5678, 0);
    check_val("store_way0_vd", sram_mem[1][54:53], 2'b11);
    check_val("store_way0_data", sram_mem[1][31:0], 32'h1234_5678);

    // Fill way1, then evict dirty way0
    access(1'b0, 32'h0000_1804, 32'd0, 2);
    access(1'b0, 32'h0000_2004, 32'd0, 2);
    check_val("writeback_landed", main_rd(32'h0000_1004 >> 2), 32'h1234_5678);

    // Long refill wait
    access(1'b0, 32'h0000_2804, 32'd0, 20);

    // Random traffic over a small conflict-heavy footprint
    for (int n = 0; n < 300; n++) begin
      logic [31:0] a;
      a = {21'($urandom_range(0, 3)), 9'($urandom_range(0, 7)), 2'b00};
      access(1'($urandom_range(0, 1)), a, $urandom, $urandom_range(0, 3));
    end
`ifdef CACHE_STATS_EN
    check_val("stats_hits", hit_count, exp_hits);
    check_val("stats_misses", miss_count, exp_misses);
`endif

    // Reset in the middle of a write-back
    access(1'b1, 32'h0000_1014, 32'hCAFE_0001, 0);
    access(1'b0, 32'h0000_2014, 32'd0, 0);
    cpu_re = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_3014;
    begin
      bit seen;
      seen = 1'b0;
      for (int c = 0; c < 10 && !seen; c++) begin
        @(negedge clk);
        if (mem_req && mem_we) seen = 1'b1;
      end
      check_val("wb_reached", seen, 1);
    end
    rst = 1'b1;
    #1;
    check_val("rst_mid_wb_mem_req", mem_req, 0);
    check_val("rst_mid_wb_stall", stall, 1);
    do_reset(2);
    access(1'b0, 32'h0000_1014, 32'd0, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dcache_controller.md
Name: dcache_controller

Overview:
- Two-way set-associative, write-back, write-allocate data-cache controller between the CPU memory stage and the cache set SRAM (512 sets × 111 bits).
- Decodes and compares tags, picks the LRU victim, writes back dirty lines and refills from main memory over a req/ready handshake.
- Drives the SRAM's combinational-read, posedge-write port directly.

Parameters:
- ADDR_WIDTH, 32, byte-address width.
- DATA_WIDTH, 32, word and line width; one word per line.
- CACHE_ADDR_WIDTH, 9, set index width.
- TAG_WIDTH (localparam), ADDR_WIDTH-CACHE_ADDR_WIDTH-2 = 21.
- SET_SIZE (localparam), 2*(TAG_WIDTH+DATA_WIDTH+2)+1 = 111.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- cpu_re  in  1  load request.
- cpu_we  in  1  store request.
- cpu_addr  in  ADDR_WIDTH  byte address; [1:0] ignored.
- cpu_wdata  in  DATA_WIDTH  store data.
- cpu_rdata  out  DATA_WIDTH  load data, valid on a hit cycle.
- stall  out  1  CPU must hold its request and pipeline.
- sram_addr  out  CACHE_ADDR_WIDTH  set index.
- sram_re  out  1  SRAM read enable.
- sram_we  out  1  SRAM write enable.
- sram_wd  out  SET_SIZE  set write data.
- sram_rd  in  SET_SIZE  set read data (combinational).
- mem_req  out  1  main-memory request.
- mem_we  out  1  1 = write-back, 0 = refill.
- mem_addr  out  ADDR_WIDTH  word-aligned memory address.
- mem_wdata  out  DATA_WIDTH  write-back data.
- mem_ready  in  1  one-cycle completion pulse.
- mem_rdata  in  DATA_WIDTH  refill data, valid with mem_ready.

Behaviour:
- Set layout: [110] LRU (names the way to evict next); way1 = [109:55]; way0 = [54:0].
- Way layout: [54] valid, [53] dirty, [52:32] tag, [31:0] data.
- Address split: tag = addr[31:11], index = addr[10:2].
- When both cpu_we and cpu_re are high, the access is treated as a store.
- Reset: while rst is high and on the reset edge, state <= INIT and init_cnt <= 0. During rst high, stall=1, mem_req=0, sram_we=0, sram_re=0, cpu_rdata=0. SRAM contents are not reset; INIT clears them.
- INIT:
  - sram_we=1, sram_addr=init_cnt, sram_wd=0, stall=1.
  - init_cnt increments each cycle; after index 2^CACHE_ADDR_WIDTH-1 is written -> IDLE.
  - INIT takes 512 cycles.
- IDLE (compare):
  - sram_re=1, sram_addr=index. hit_w = valid_w && tag_w==tag; at most one way hits.
  - No request: stall=0, sram_we=0.
  - Read hit, zero added latency: cpu_rdata = hit way data combinationally; stall=0; sram_we=1 rewriting the set with LRU = other way.
  - Write hit: stall=0; sram_we=1 with hit way data=cpu_wdata, dirty=1, LRU = other way.
  - Miss: stall=1, sram_we=0. Latch victim way (= LRU bit), request tag/index, and victim tag/data.
    - Victim valid && dirty -> WRITEBACK; else -> ALLOCATE.
- WRITEBACK:
  - mem_req=1, mem_we=1, mem_addr={victim_tag,index,2'b00}, mem_wdata=victim data.
  - Signals held stable until mem_ready; mem_ready -> ALLOCATE.
- ALLOCATE:
  - mem_req=1, mem_we=0, mem_addr={req_tag,index,2'b00}.
  - On mem_ready: sram_we=1 with victim way = {1,0,req_tag,mem_rdata}; other way and LRU unchanged; -> IDLE.
  - The held CPU request replays in IDLE and hits.
  - Miss latency with clean victim = 1 + memory latency + 1 replay cycle.
- stall=1 throughout WRITEBACK and ALLOCATE.
- cpu_rdata=0 whenever not a read hit.
- mem_ready outside WRITEBACK/ALLOCATE is ignored.
- mem_req is 0 in INIT and IDLE.
- Reset asserted mid-WRITEBACK or mid-ALLOCATE aborts the transaction: mem_req=0 from the reset cycle, and INIT re-runs.

Optional Feature:
- CACHE_STATS_EN defined: adds outputs hit_count and miss_count, 32 bits each, wrap-around.
  - hit_count increments on each IDLE hit except the replay cycle following ALLOCATE (replay flag register).
  - miss_count increments once per IDLE miss detection.
  - Both counters reset to 0.
- CACHE_STATS_EN undefined: ports and counters absent; all other behaviour identical.

Decomposition:
- Package cache_pkg: TAG_WIDTH and SET_SIZE constants; way_t packed struct {valid, dirty, tag, data}; set_t packed struct {lru, way1, way0}; state_t enum {INIT, IDLE, WRITEBACK, ALLOCATE}.
- Sub-module cache_way_cmp (instantiated twice): takes way_t and tag, outputs hit.

Test Plan:
- Reset, then 512 cycles -> stall=1 for exactly 512 cycles, sram_we=1 across addrs 0..511 with wd=0; then stall=0.
- Load 0x0000_1004 cold -> miss, no WRITEBACK. ALLOCATE with mem_addr=0x0000_1004, mem_rdata=0xDEADBEEF after 3 cycles. Replay hit returns 0xDEADBEEF with stall=0; set LRU=1 (way0 filled).
- Store 0x12345678 to 0x0000_1004 after the fill -> same-cycle hit, stall=0. Way0 dirty=1, data=0x12345678.
- Load 0x0000_1804 then 0x0000_2004 (same index 1) -> second miss evicts dirty way0. WRITEBACK mem_addr=0x0000_1004, mem_wdata=0x12345678, then ALLOCATE 0x0000_2004.
- Hold mem_ready=0 for 20 cycles in ALLOCATE -> mem_req, mem_addr stable and stall=1 throughout; no SRAM write until mem_ready.
- Assert rst mid-WRITEBACK -> mem_req=0 that cycle; INIT re-runs. With CACHE_STATS_EN, counters read 0.
